// File: rtl/lfsr_pkg.sv
// lfsr_pkg
// Shared definitions for the LFSR packet decryptor:
//   LFSR_W         default LFSR state width
//   PREAMBLE_CHAR  value every decrypted preamble byte must equal
//   PAYLOAD_MARK   bit that must be set on every encrypted payload byte
//   state_t        decryptor control states
package lfsr_pkg;

    localparam int         LFSR_W        = 5;
    localparam logic [7:0] PREAMBLE_CHAR = 8'h7E;
    localparam logic [7:0] PAYLOAD_MARK  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core
// Fibonacci-style shift register that generates the keystream.
// Each advance shifts left and inserts the XOR of the tapped bits at bit 0.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (state cleared to 0)
//   i_load     load i_seed (has priority over i_advance)
//   i_advance  step the register once
//   i_seed     value loaded on i_load
//   i_taps     feedback tap mask
//   o_lfsr     current register state
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int W = LFSR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [W-1:0] i_seed,
    input  logic [W-1:0] i_taps,
    output logic [W-1:0] o_lfsr
);

    logic [W-1:0] r_lfsr;
    logic [W-1:0] w_tapped;
    logic         w_feedback;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_tap
            assign w_tapped[gi] = r_lfsr[gi] & i_taps[gi];
        end
    endgenerate

    assign w_feedback = ^w_tapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= '0;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_advance) begin
            r_lfsr <= {r_lfsr[W-2:0], w_feedback};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/lfsr_decrypt.sv
// lfsr_decrypt
// Decrypts a packet made of preLen preamble bytes followed by payLen payload
// bytes. Each accepted byte is XORed with the zero-extended LFSR state, after
// which the LFSR steps once. Decrypted payload bytes are output with bit 7
// cleared, one cycle after acceptance.
// Optional feature: define LFSR_DECRYPT_PREAMBLE_CHECK_EN to compare every
// decrypted preamble byte with PREAMBLE_CHAR; otherwise preambleErr stays 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   decRqst             start request (IDLE only), latches preLen/taps/seed/payLen
//   preLen, payLen      preamble / payload byte counts (0 skips the phase)
//   taps, seed          LFSR feedback mask and initial state
//   validIn, encByte    encrypted byte stream
//   plainByte, validOut decrypted payload byte and its strobe
//   done                one-cycle end-of-packet pulse
//   preambleErr         sticky preamble mismatch flag
//   bit7Err             sticky flag: payload byte arrived with bit 7 clear
module lfsr_decrypt #(
    parameter int DW     = 8,
    parameter int LFSR_W = lfsr_pkg::LFSR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              decRqst,
    input  logic [7:0]        preLen,
    input  logic [LFSR_W-1:0] taps,
    input  logic [LFSR_W-1:0] seed,
    input  logic [7:0]        payLen,
    input  logic              validIn,
    input  logic [DW-1:0]     encByte,
    output logic [DW-1:0]     plainByte,
    output logic              validOut,
    output logic              done,
    output logic              preambleErr,
    output logic              bit7Err
);
    import lfsr_pkg::*;

    state_t            r_state;
    logic [7:0]        r_pre_len;
    logic [7:0]        r_pay_len;
    logic [LFSR_W-1:0] r_taps;
    logic [LFSR_W-1:0] r_seed;
    logic [7:0]        r_cnt;
    logic [DW-1:0]     r_plain;
    logic              r_valid;
    logic              r_done;
    logic              r_bit7_err;
`ifdef LFSR_DECRYPT_PREAMBLE_CHECK_EN
    logic              r_preamble_err;
`endif

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_accept;
    logic [DW-1:0]     w_dec;
    logic [7:0]        w_cnt_inc;
    logic              w_last;

    // Bytes are only consumed in the two data phases; validIn elsewhere is dropped.
    assign w_accept  = validIn && ((r_state == ST_PREAMBLE) || (r_state == ST_PAYLOAD));
    assign w_dec     = encByte ^ {{(DW-LFSR_W){1'b0}}, w_lfsr};
    assign w_cnt_inc = r_cnt + 8'd1;
    // Compare against count+1 so a length of 255 finishes without the counter wrapping.
    assign w_last    = (w_cnt_inc == ((r_state == ST_PREAMBLE) ? r_pre_len : r_pay_len));

    lfsr_core #(
        .W (LFSR_W)
    ) u_lfsr_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == ST_LOAD),
        .i_advance (w_accept),
        .i_seed    (r_seed),
        .i_taps    (r_taps),
        .o_lfsr    (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pre_len  <= '0;
            r_pay_len  <= '0;
            r_taps     <= '0;
            r_seed     <= '0;
            r_cnt      <= '0;
            r_plain    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_bit7_err <= 1'b0;
`ifdef LFSR_DECRYPT_PREAMBLE_CHECK_EN
            r_preamble_err <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (decRqst) begin
                        r_pre_len  <= preLen;
                        r_pay_len  <= payLen;
                        r_taps     <= taps;
                        r_seed     <= seed;
                        r_bit7_err <= 1'b0;
`ifdef LFSR_DECRYPT_PREAMBLE_CHECK_EN
                        r_preamble_err <= 1'b0;
`endif
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt <= '0;
                    if (r_pre_len != 8'd0) begin
                        r_state <= ST_PREAMBLE;
                    end else if (r_pay_len != 8'd0) begin
                        r_state <= ST_PAYLOAD;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_accept) begin
`ifdef LFSR_DECRYPT_PREAMBLE_CHECK_EN
                        if (w_dec != PREAMBLE_CHAR) begin
                            r_preamble_err <= 1'b1;
                        end
`endif
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_pay_len != 8'd0) begin
                                r_state <= ST_PAYLOAD;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_plain <= w_dec & ~PAYLOAD_MARK;
                        r_valid <= 1'b1;
                        if ((encByte & PAYLOAD_MARK) == '0) begin
                            r_bit7_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign plainByte = r_plain;
    assign validOut  = r_valid;
    assign done      = r_done;
    assign bit7Err   = r_bit7_err;
`ifdef LFSR_DECRYPT_PREAMBLE_CHECK_EN
    assign preambleErr = r_preamble_err;
`else
    assign preambleErr = 1'b0;
`endif

endmodule
